// File: rtl/fp_mul_seq.sv
// Iterative binary64 multiplier: radix-2 shift-add significand core, RNE rounding, IEEE flags.
// Valid/ready on both sides; operands accepted only in IDLE, result held in DONE until out_ready.
module fp_mul_seq #(
  parameter int MANT_W   = 53,
  parameter int EXP_BIAS = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic [3:0]  flags
);
  localparam int ACC_W = 2 * MANT_W;
  localparam logic signed [12:0] BIAS = 13'(EXP_BIAS);
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_RND, S_DONE} state_t;
  typedef struct packed {
    logic [12:0]       e;
    logic [MANT_W-1:0] m;
  } op_t;

  function automatic logic [5:0] lzc(input logic [MANT_W-1:0] v);
    lzc = 6'(MANT_W);
    for (int i = 0; i < MANT_W; i++)
      if (v[i]) lzc = 6'(MANT_W - 1 - i);
  endfunction

  // Subnormals are normalised so the significand MSB is always set.
  function automatic op_t unpack(input logic [63:0] x);
    op_t r;
    logic [MANT_W-1:0] m;
    logic [5:0] lz;
    m  = {1'b0, x[51:0]};
    lz = lzc(m);
    if (x[62:52] == 11'd0) begin
      r.m = m << lz;
      r.e = 13'd1 - 13'(lz);
    end else begin
      r.m = {1'b1, x[51:0]};
      r.e = {2'b00, x[62:52]};
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [63:0]       result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic              sign_q, sign_d;
  logic signed [12:0] exp_q, exp_d;
  logic [MANT_W-1:0] ma_q, ma_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [51:0]       frac_q, frac_d;
  logic              guard_q, guard_d, sticky_q, sticky_d;

  op_t               op_a, op_b;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sig_nan;
  logic [MANT_W:0]   mul_sum;
  logic              rnd_up, inexact;
  logic [52:0]       frac_sum;
  logic signed [12:0] exp_rnd;

  assign op_a    = unpack(a);
  assign op_b    = unpack(b);
  assign a_nan   = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
  assign b_nan   = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
  assign a_inf   = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
  assign b_inf   = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
  assign a_zero  = (a[62:0] == 63'd0);
  assign b_zero  = (b[62:0] == 63'd0);
  assign sig_nan = (a_nan && !a[51]) || (b_nan && !b[51]);

  // Upper half accumulates, whole register shifts right one multiplier bit per cycle.
  assign mul_sum  = {1'b0, acc_q[ACC_W-1:MANT_W]} + (acc_q[0] ? {1'b0, ma_q} : '0);
  assign rnd_up   = guard_q && (sticky_q || frac_q[0]);
  assign inexact  = guard_q || sticky_q;
  assign frac_sum = {1'b0, frac_q} + {52'd0, rnd_up};
  assign exp_rnd  = frac_sum[52] ? exp_q + 13'sd1 : exp_q;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    ma_d        = ma_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    frac_d      = frac_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d      = a[63] ^ b[63];
          in_ready_d  = 1'b0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          flags_d     = 4'b0000;
          if (a_nan || b_nan) begin
            result_d = QNAN;
            flags_d  = {sig_nan, 3'b000};
          end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            result_d = QNAN;
            flags_d  = 4'b1000;
          end else if (a_inf || b_inf) begin
            result_d = {a[63] ^ b[63], 11'h7FF, 52'd0};
          end else if (a_zero || b_zero) begin
            result_d = {a[63] ^ b[63], 63'd0};
          end else begin
            state_d     = S_MUL;
            out_valid_d = 1'b0;
            ma_d        = op_a.m;
            acc_d       = {{MANT_W{1'b0}}, op_b.m};
            exp_d       = $signed(op_a.e) + $signed(op_b.e) - BIAS;
            cnt_d       = 6'd0;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[MANT_W-1:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MANT_W - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (acc_q[ACC_W-1]) begin
          frac_d   = acc_q[ACC_W-2 -: 52];
          guard_d  = acc_q[MANT_W-1];
          sticky_d = |acc_q[MANT_W-2:0];
          exp_d    = exp_q + 13'sd1;
        end else begin
          frac_d   = acc_q[ACC_W-3 -: 52];
          guard_d  = acc_q[MANT_W-2];
          sticky_d = |acc_q[MANT_W-3:0];
        end
        state_d = S_RND;
      end
      S_RND: begin
        if (exp_rnd >= 13'sd2047) begin
          result_d = {sign_q, 11'h7FF, 52'd0};
          flags_d  = 4'b0101;
        end else if (exp_rnd <= 13'sd0) begin
          result_d = {sign_q, 63'd0};
          flags_d  = 4'b0011;
        end else begin
          result_d = {sign_q, exp_rnd[10:0], frac_sum[51:0]};
          flags_d  = {3'b000, inexact};
        end
        state_d     = S_DONE;
        out_valid_d = 1'b1;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 64'd0;
      flags_q     <= 4'd0;
      sign_q      <= 1'b0;
      exp_q       <= 13'sd0;
      ma_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= 6'd0;
      frac_q      <= 52'd0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      ma_q        <= ma_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      frac_q      <= frac_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed vectors, random operands against an integer reference model,
// output stall, busy-input rejection, mid-operation reset and back-to-back operations.
module tb_fp_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic        in_ready, out_valid;
  logic [63:0] result;
  logic [3:0]  flags;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fp_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  logic [63:0] dir_a [6] = '{64'h4008000000000000, 64'h3FD5555555555555, 64'h7FEFFFFFFFFFFFFF,
                             64'h0000000000000000, 64'h0000000000000001, 64'h0010000000000000};
  logic [63:0] dir_b [6] = '{64'h4000000000000000, 64'h4008000000000000, 64'h4000000000000000,
                             64'h7FF0000000000000, 64'h4330000000000000, 64'h3FE0000000000000};
  logic [63:0] dir_r [6] = '{64'h4018000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000,
                             64'h7FF8000000000000, 64'h0010000000000000, 64'h0000000000000000};
  logic [3:0]  dir_f [6] = '{4'b0000, 4'b0001, 4'b0101, 4'b1000, 4'b0000, 4'b0011};
  int          dir_l [6] = '{56, 56, 56, 1, 56, 56};

  // Reference: exact integer product, rounding by comparing the discarded remainder with one half.
  function automatic void ref_mul(input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] r, output logic [3:0] f);
    logic s, xnan, ynan, xinf, yinf, xzero, yzero, up;
    logic [105:0] mx, my, p, kept, rem, half;
    int ex, ey, e, sh;
    s     = x[63] ^ y[63];
    xnan  = (x[62:52] == 11'h7FF) && (x[51:0] != 0);
    ynan  = (y[62:52] == 11'h7FF) && (y[51:0] != 0);
    xinf  = (x[62:52] == 11'h7FF) && (x[51:0] == 0);
    yinf  = (y[62:52] == 11'h7FF) && (y[51:0] == 0);
    xzero = (x[62:0] == 0);
    yzero = (y[62:0] == 0);
    f = 4'b0000;
    if (xnan || ynan) begin
      r = 64'h7FF8000000000000;
      f[3] = (xnan && !x[51]) || (ynan && !y[51]);
      return;
    end
    if ((xzero && yinf) || (xinf && yzero)) begin
      r = 64'h7FF8000000000000; f = 4'b1000; return;
    end
    if (xinf || yinf) begin r = {s, 11'h7FF, 52'd0}; return; end
    if (xzero || yzero) begin r = {s, 63'd0}; return; end
    mx = {54'd0, x[51:0]}; my = {54'd0, y[51:0]};
    if (x[62:52] == 0) begin
      ex = 1;
      while (mx[52] == 1'b0) begin mx = mx << 1; ex--; end
    end else begin mx[52] = 1'b1; ex = int'(x[62:52]); end
    if (y[62:52] == 0) begin
      ey = 1;
      while (my[52] == 1'b0) begin my = my << 1; ey--; end
    end else begin my[52] = 1'b1; ey = int'(y[62:52]); end
    p  = mx * my;
    e  = ex + ey - 1023;
    sh = p[105] ? 53 : 52;
    if (p[105]) e++;
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = 106'd1 << (sh - 1);
    up   = (rem > half) || ((rem == half) && kept[0]);
    kept = kept + {105'd0, up};
    if (kept[53]) begin kept = kept >> 1; e++; end
    if (e >= 2047) begin r = {s, 11'h7FF, 52'd0}; f = 4'b0101; end
    else if (e <= 0) begin r = {s, 63'd0}; f = 4'b0011; end
    else begin r = {s, 11'(e), kept[51:0]}; f = {3'b000, rem != 0}; end
  endfunction

  function automatic logic [63:0] rand_norm();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return {t[63], 11'($urandom_range(900, 1150)), t[51:0]};
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] t;
    int sel;
    t = {$urandom, $urandom};
    sel = $urandom_range(0, 11);
    case (sel)
      0: return {t[63], 63'd0};
      1: return {t[63], 11'h7FF, 52'd0};
      2: return {t[63], 11'h7FF, t[51], t[50:1], 1'b1};
      3: return {t[63], 11'h000, t[51:1], 1'b1};
      4: return {t[63], 11'($urandom_range(1900, 2046)), t[51:0]};
      5: return {t[63], 11'($urandom_range(1, 150)), t[51:0]};
      default: return rand_norm();
    endcase
  endfunction

  // Drives one operation and returns what the DUT produced; leaves the DUT back in IDLE.
  task automatic run_op(input logic [63:0] x, input logic [63:0] y, output logic [63:0] r,
                        output logic [3:0] f, output int lat, output bit to);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 1; to = 1'b0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    to = !out_valid;
    r = result; f = flags;
    if (!to) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (flags !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [63:0] r; logic [3:0] f; int lat; bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(dir_a[i], dir_b[i], r, f, lat, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL dir_timeout[%0d]: no out_valid within 200 cycles", i); end
      n_checks++; if (r !== dir_r[i]) begin n_fail++; $display("FAIL dir_result[%0d]: got %h want %h", i, r, dir_r[i]); end
      n_checks++; if (f !== dir_f[i]) begin n_fail++; $display("FAIL dir_flags[%0d]: got %b want %b", i, f, dir_f[i]); end
      n_checks++; if (lat != dir_l[i]) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, dir_l[i]); end
    end
  endtask

  task automatic test_random;
    logic [63:0] x, y, r, er; logic [3:0] f, ef; int lat; bit to;
    for (int i = 0; i < 40; i++) begin
      x = rand_op(); y = rand_op();
      ref_mul(x, y, er, ef);
      run_op(x, y, r, f, lat, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rnd_timeout[%0d]: %h x %h", i, x, y); end
      n_checks++; if (r !== er) begin n_fail++; $display("FAIL rnd_result[%0d]: %h x %h got %h want %h", i, x, y, r, er); end
      n_checks++; if (f !== ef) begin n_fail++; $display("FAIL rnd_flags[%0d]: %h x %h got %b want %b", i, x, y, f, ef); end
    end
  endtask

  task automatic test_stall;
    logic [63:0] x, y, er; logic [3:0] ef; int lat;
    x = rand_norm(); y = rand_norm();
    ref_mul(x, y, er, ef);
    out_ready = 1'b0;
    @(negedge clk); a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: out_valid %b want 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (result !== er) begin n_fail++; $display("FAIL stall_result[%0d]: got %h want %h", i, result, er); end
      n_checks++; if (flags !== ef) begin n_fail++; $display("FAIL stall_flags[%0d]: got %b want %b", i, flags, ef); end
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hs[%0d]: out_valid %b in_ready %b want 1 0", i, out_valid, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_busy;
    logic [63:0] x, y, er; logic [3:0] ef; int lat;
    x = rand_norm(); y = rand_norm();
    ref_mul(x, y, er, ef);
    @(negedge clk); a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      a = rand_norm(); b = rand_norm();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready[%0d]: got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 21;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_checks++; if (result !== er || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL busy_result: got %h valid %b want %h", result, out_valid, er); end
    n_checks++; if (flags !== ef) begin n_fail++; $display("FAIL busy_flags: got %b want %b", flags, ef); end
    n_checks++; if (lat != 56) begin n_fail++; $display("FAIL busy_latency: got %0d want 56", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; logic [3:0] f; int lat, seen; bit to;
    @(negedge clk); a = rand_norm(); b = rand_norm(); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 70; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_ghost: %0d out_valid cycles want 0", seen); end
    run_op(dir_a[0], dir_b[0], r, f, lat, to);
    n_checks++; if (r !== dir_r[0] || to) begin n_fail++; $display("FAIL midrst_recover: got %h want %h", r, dir_r[0]); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] x1, y1, x2, y2, e1, e2, r1, r2; logic [3:0] ef1, ef2, f1, f2;
    int cyc, got, c1, c2; bit drop_next;
    x1 = rand_norm(); y1 = rand_norm(); x2 = rand_norm(); y2 = rand_norm();
    ref_mul(x1, y1, e1, ef1); ref_mul(x2, y2, e2, ef2);
    r1 = '0; r2 = '0; f1 = '0; f2 = '0; c1 = 0; c2 = 0;
    @(negedge clk); a = x1; b = y1; in_valid = 1'b1;
    @(posedge clk); #1; a = x2; b = y2;
    cyc = 1; got = 0; drop_next = 1'b0;
    while (got < 2 && cyc < 400) begin
      if (out_valid) begin
        if (got == 0) begin r1 = result; f1 = flags; c1 = cyc; end
        else begin r2 = result; f2 = flags; c2 = cyc; end
        got++;
      end
      if (got < 2) begin
        if (in_ready && in_valid) drop_next = 1'b1;
        @(posedge clk); #1; cyc++;
        if (drop_next) begin in_valid = 1'b0; drop_next = 1'b0; end
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 2) begin n_fail++; $display("FAIL b2b_count: got %0d results want 2", got); end
    n_checks++; if (r1 !== e1 || f1 !== ef1) begin n_fail++; $display("FAIL b2b_first: got %h/%b want %h/%b", r1, f1, e1, ef1); end
    n_checks++; if (r2 !== e2 || f2 !== ef2) begin n_fail++; $display("FAIL b2b_second: got %h/%b want %h/%b", r2, f2, e2, ef2); end
    n_checks++; if (c2 - c1 != 57) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 57", c2 - c1); end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
